rf_access_ctrl: RTL and testbench
=================================

RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, data path width.
REQ-002 SHALL have parameter D, default 4, register pointer width (2**D registers).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1: operand-read request handshake.
REQ-006 SHALL have ports req_addr_a, req_addr_b  input  D each: source register pointers.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1: operand response handshake.
REQ-008 SHALL have ports rsp_a, rsp_b  output  W each: captured operand values.
REQ-009 SHALL have ports wb_valid input 1, wb_ready output 1, wb_addr input D, wb_data input W: writeback request.
REQ-010 SHALL have ports rf_write_en output 1, rf_addr output D, rf_data_in output W: drive to downstream single-port register file.
REQ-011 SHALL have port rf_data_out  input  W: combinational read data returned by the register file for rf_addr.

Function
REQ-012 SHALL implement FSM states IDLE, READ_A, READ_B, RESP.
REQ-013 IDLE: wb_valid=1 -> wb_ready=1, rf_write_en=1, rf_addr=wb_addr, rf_data_in=wb_data; req_ready=0 that cycle (writeback priority).
REQ-014 IDLE: wb_valid=0 -> req_ready=1; req_valid=1 latches req_addr_a/b, next state READ_A.
REQ-015 READ_A: rf_addr=latched addr_a, rf_write_en=0; rf_data_out captured into rsp_a at cycle end.
REQ-016 READ_A -> READ_B if addr_a!=addr_b; else -> RESP with rsp_b also loaded from rf_data_out (single read).
REQ-017 READ_B: rf_addr=latched addr_b, rf_write_en=0; rf_data_out captured into rsp_b; next state RESP.
REQ-018 RESP: rsp_valid=1; rsp_a/rsp_b held stable until rsp_valid&&rsp_ready; then -> IDLE.
REQ-019 RESP: wb_valid=1 -> writeback performed as in REQ-013 (port free); req_ready=0.
REQ-020 READ_A/READ_B: wb_ready=0, req_ready=0; rf_write_en never asserted.
REQ-021 Latency: request accepted at edge E0 -> rsp_valid high cycle after E2 (distinct addrs) or after E1 (equal addrs).
REQ-022 Snapshot semantics: writeback during RESP to addr_a/addr_b SHALL NOT alter held rsp_a/rsp_b (no forwarding).
REQ-023 Writeback accepted in a cycle is visible to any read in a later cycle (write-before-read ordering).
REQ-024 rf_addr SHALL be 0 and rf_data_in 0 when no read or write is driven.
REQ-025 Address 0 SHALL be writable and readable like any other register.
REQ-026 At most one of {write, read} on the RF port per cycle.

Reset
REQ-027 Reset=1 at posedge -> state IDLE, rsp_valid=0, rsp_a=rsp_b=0, latched addrs=0.
REQ-028 Reset asserted mid-operation (any state) aborts the transaction; no response issued.
REQ-029 While Reset=1: rf_write_en=0, wb_ready=0, req_ready=0, regardless of inputs.

Verification
REQ-030 Write r3=0x5A, r7=0xC3 via wb; req a=3,b=7 -> rsp_a=0x5A, rsp_b=0xC3, rsp_valid 3 cycles after accept.
REQ-031 req a=b=5 (r5=0x11) -> single READ_A cycle, rsp_a=rsp_b=0x11, rsp_valid 2 cycles after accept.
REQ-032 wb_valid and req_valid both 1 in IDLE -> wb accepted first, req accepted next cycle, reads see new value.
REQ-033 RESP with rsp_ready=0 for 4 cycles plus wb to addr_a=0xFF -> rsp_a unchanged, wb_ready=1, RF updated.
REQ-034 Reset pulse in READ_B -> IDLE next cycle, rsp_valid=0, no rf_write_en; new request completes normally.
REQ-035 Write r0=0x80, req a=0,b=15 -> rsp_a=0x80.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// Operand-read controller for a single-port register file.
// Writebacks take priority whenever the port is free (IDLE or RESP); operand
// reads take one RF cycle per distinct source register, and the captured
// operands are held as a snapshot until the response handshake completes.
module rf_access_ctrl #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_addr_a,
  input  logic [D-1:0] req_addr_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_a,
  output logic [W-1:0] rsp_b,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [D-1:0] wb_addr,
  input  logic [W-1:0] wb_data,
  output logic         rf_write_en,
  output logic [D-1:0] rf_addr,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    READ_A,
    READ_B,
    RESP
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   addrA_q, addrA_d;
  logic [D-1:0]   addrB_q, addrB_d;
  logic [W-1:0]   rspA_q, rspA_d;
  logic [W-1:0]   rspB_q, rspB_d;

  // State, latched source pointers and operand snapshot; reset aborts any transaction.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      addrA_q <= '0;
      addrB_q <= '0;
      rspA_q  <= '0;
      rspB_q  <= '0;
    end else begin
      state_q <= state_d;
      addrA_q <= addrA_d;
      addrB_q <= addrB_d;
      rspA_q  <= rspA_d;
      rspB_q  <= rspB_d;
    end
  end

  // Next-state and port control; everything is forced idle while Reset is high.
  always_comb begin
    state_d     = state_q;
    addrA_d     = addrA_q;
    addrB_d     = addrB_q;
    rspA_d      = rspA_q;
    rspB_d      = rspB_q;
    req_ready   = 1'b0;
    wb_ready    = 1'b0;
    rsp_valid   = 1'b0;
    rf_write_en = 1'b0;
    rf_addr     = '0;
    rf_data_in  = '0;
    if (!Reset) begin
      case (state_q)
        IDLE: begin
          wb_ready = 1'b1;
          if (wb_valid) begin
            rf_write_en = 1'b1;
            rf_addr     = wb_addr;
            rf_data_in  = wb_data;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              addrA_d = req_addr_a;
              addrB_d = req_addr_b;
              state_d = READ_A;
            end
          end
        end
        READ_A: begin
          rf_addr = addrA_q;
          rspA_d  = rf_data_out;
          if (addrA_q == addrB_q) begin
            rspB_d  = rf_data_out;
            state_d = RESP;
          end else begin
            state_d = READ_B;
          end
        end
        READ_B: begin
          rf_addr = addrB_q;
          rspB_d  = rf_data_out;
          state_d = RESP;
        end
        RESP: begin
          rsp_valid = 1'b1;
          wb_ready  = 1'b1;
          if (wb_valid) begin
            rf_write_en = 1'b1;
            rf_addr     = wb_addr;
            rf_data_in  = wb_data;
          end
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rsp_a = rspA_q;
  assign rsp_b = rspB_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: a directed vector table, a reset
// abort sequence and randomized traffic, all compared against a transaction
// level model (pending-read queue plus a model register file).
module tb_rf_access_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         reqValid;
  logic         reqReady;
  logic [D-1:0] reqAddrA;
  logic [D-1:0] reqAddrB;
  logic         rspValid;
  logic         rspReady;
  logic [W-1:0] rspA;
  logic [W-1:0] rspB;
  logic         wbValid;
  logic         wbReady;
  logic [D-1:0] wbAddr;
  logic [W-1:0] wbData;
  logic         rfWriteEn;
  logic [D-1:0] rfAddr;
  logic [W-1:0] rfDataIn;
  logic [W-1:0] rfDataOut;

  int checks   = 0;
  int failures = 0;

  // Clock generation.
  always #5 CLK = ~CLK;

  rf_access_ctrl #(.W(W), .D(D)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_addr_a (reqAddrA),
    .req_addr_b (reqAddrB),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_a      (rspA),
    .rsp_b      (rspB),
    .wb_valid   (wbValid),
    .wb_ready   (wbReady),
    .wb_addr    (wbAddr),
    .wb_data    (wbData),
    .rf_write_en(rfWriteEn),
    .rf_addr    (rfAddr),
    .rf_data_in (rfDataIn),
    .rf_data_out(rfDataOut)
  );

  // Downstream single-port register file: combinational read, write at the edge.
  logic [W-1:0] rfMem [2**D] = '{default: '0};
  assign rfDataOut = rfMem[rfAddr];
  always @(posedge CLK) begin
    if (rfWriteEn) rfMem[rfAddr] <= rfDataIn;
  end

  // Reference model state.
  typedef struct {
    int addr;
    bit toA;
    bit toB;
  } readOp_t;

  readOp_t      pending[$];
  bit           holding;
  logic [W-1:0] modelMem [2**D];
  logic [W-1:0] mA;
  logic [W-1:0] mB;

  typedef struct {
    int rst; int wbV; int wbA; int wbD; int rqV; int aA; int aB; int rdy;
    int eReqRdy; int eWbRdy; int eWe; int eAddr; int eRspV; int eA; int eB;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int rst, input int wbV, input int wbA, input int wbD,
                               input int rqV, input int aA, input int aB, input int rdy);
    Reset    = (rst != 0);
    wbValid  = (wbV != 0);
    wbAddr   = wbA[D-1:0];
    wbData   = wbD[W-1:0];
    reqValid = (rqV != 0);
    reqAddrA = aA[D-1:0];
    reqAddrB = aB[D-1:0];
    rspReady = (rdy != 0);
    #1;
  endtask

  // Compare every output with what the model predicts for the current inputs.
  task automatic checkModel();
    logic         eReqRdy, eWbRdy, eWe, eRspV;
    logic [D-1:0] eAddr;
    logic [W-1:0] eData;
    int           headAddr;
    eReqRdy = 1'b0; eWbRdy = 1'b0; eWe = 1'b0; eRspV = 1'b0;
    eAddr   = '0;   eData  = '0;
    if (!Reset) begin
      if (pending.size() != 0) begin
        headAddr = pending[0].addr;
        eAddr    = headAddr[D-1:0];
      end else begin
        eWbRdy  = 1'b1;
        eRspV   = holding;
        eReqRdy = !holding && !wbValid;
        if (wbValid) begin
          eWe   = 1'b1;
          eAddr = wbAddr;
          eData = wbData;
        end
      end
    end
    checkOutput("model.req_ready",   32'(reqReady),  32'(eReqRdy));
    checkOutput("model.wb_ready",    32'(wbReady),   32'(eWbRdy));
    checkOutput("model.rf_write_en", 32'(rfWriteEn), 32'(eWe));
    checkOutput("model.rf_addr",     32'(rfAddr),    32'(eAddr));
    checkOutput("model.rf_data_in",  32'(rfDataIn),  32'(eData));
    checkOutput("model.rsp_valid",   32'(rspValid),  32'(eRspV));
    checkOutput("model.rsp_a",       32'(rspA),      32'(mA));
    checkOutput("model.rsp_b",       32'(rspB),      32'(mB));
  endtask

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic advance();
    readOp_t op;
    if (Reset) begin
      pending.delete();
      holding = 1'b0;
      mA = '0;
      mB = '0;
    end else if (pending.size() != 0) begin
      op = pending.pop_front();
      if (op.toA) mA = modelMem[op.addr];
      if (op.toB) mB = modelMem[op.addr];
      if (pending.size() == 0) holding = 1'b1;
    end else begin
      if (wbValid) modelMem[wbAddr] = wbData;
      if (holding) begin
        if (rspReady) holding = 1'b0;
      end else if (!wbValid && reqValid) begin
        pending.push_back('{int'(reqAddrA), 1'b1, reqAddrA == reqAddrB});
        if (reqAddrA != reqAddrB) pending.push_back('{int'(reqAddrB), 1'b0, 1'b1});
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cycle(input int rst, input int wbV, input int wbA, input int wbD,
                       input int rqV, input int aA, input int aB, input int rdy);
    applyStimulus(rst, wbV, wbA, wbD, rqV, aA, aB, rdy);
    checkModel();
    advance();
  endtask

  initial begin
    // Fields: rst wbV wbA wbD rqV aA aB rdy | reqRdy wbRdy we rfAddr rspV rspA rspB
    vecs.push_back('{1,1,3,'h77,1,3,7,1,  0,0,0,0,0,'h00,'h00});
    vecs.push_back('{0,1,3,'h5A,0,0,0,0,  0,1,1,3,0,'h00,'h00});
    vecs.push_back('{0,1,7,'hC3,0,0,0,0,  0,1,1,7,0,'h00,'h00});
    vecs.push_back('{0,0,0,0,1,3,7,0,     1,1,0,0,0,'h00,'h00});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,3,0,'h00,'h00});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,7,0,'h5A,'h00});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,1,0,0,1,'h5A,'hC3});
    vecs.push_back('{0,0,0,0,0,0,0,1,     0,1,0,0,1,'h5A,'hC3});
    vecs.push_back('{0,1,5,'h11,0,0,0,0,  0,1,1,5,0,'h5A,'hC3});
    vecs.push_back('{0,0,0,0,1,5,5,0,     1,1,0,0,0,'h5A,'hC3});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,5,0,'h5A,'hC3});
    vecs.push_back('{0,0,0,0,0,0,0,1,     0,1,0,0,1,'h11,'h11});
    vecs.push_back('{0,1,9,'h66,1,9,3,0,  0,1,1,9,0,'h11,'h11});
    vecs.push_back('{0,0,0,0,1,9,3,0,     1,1,0,0,0,'h11,'h11});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,9,0,'h11,'h11});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,3,0,'h66,'h11});
    vecs.push_back('{0,1,9,'hFF,0,0,0,0,  0,1,1,9,1,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,1,0,0,1,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,1,0,0,1,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,1,0,0,1,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,1,     0,1,0,0,1,'h66,'h5A});
    vecs.push_back('{0,0,0,0,1,9,9,0,     1,1,0,0,0,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,9,0,'h66,'h5A});
    vecs.push_back('{0,0,0,0,0,0,0,1,     0,1,0,0,1,'hFF,'hFF});
    vecs.push_back('{0,1,0,'h80,0,0,0,0,  0,1,1,0,0,'hFF,'hFF});
    vecs.push_back('{0,0,0,0,1,0,15,0,    1,1,0,0,0,'hFF,'hFF});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,0,0,'hFF,'hFF});
    vecs.push_back('{0,0,0,0,0,0,0,0,     0,0,0,15,0,'h80,'hFF});
    vecs.push_back('{0,0,0,0,0,0,0,1,     0,1,0,0,1,'h80,'h00});

    for (int i = 0; i < 2**D; i++) modelMem[i] = '0;
    pending.delete();
    holding = 1'b0;
    mA = '0;
    mB = '0;

    // Initial reset before any checking; registers are unknown until it lands.
    Reset = 1'b1; wbValid = 1'b0; wbAddr = '0; wbData = '0;
    reqValid = 1'b0; reqAddrA = '0; reqAddrB = '0; rspReady = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wbV, vecs[i].wbA, vecs[i].wbD,
                    vecs[i].rqV, vecs[i].aA, vecs[i].aB, vecs[i].rdy);
      checkModel();
      checkOutput($sformatf("vec%0d.req_ready", i),   32'(reqReady),  vecs[i].eReqRdy);
      checkOutput($sformatf("vec%0d.wb_ready", i),    32'(wbReady),   vecs[i].eWbRdy);
      checkOutput($sformatf("vec%0d.rf_write_en", i), 32'(rfWriteEn), vecs[i].eWe);
      checkOutput($sformatf("vec%0d.rf_addr", i),     32'(rfAddr),    vecs[i].eAddr);
      checkOutput($sformatf("vec%0d.rsp_valid", i),   32'(rspValid),  vecs[i].eRspV);
      checkOutput($sformatf("vec%0d.rsp_a", i),       32'(rspA),      vecs[i].eA);
      checkOutput($sformatf("vec%0d.rsp_b", i),       32'(rspB),      vecs[i].eB);
      advance();
    end

    $display("[TB] reset abort during second read");
    cycle(0, 1, 2, 'h21, 0, 0, 0, 0);
    cycle(0, 1, 4, 'h42, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 'hEE, 1, 6, 6, 1);
    checkModel();
    checkOutput("abort.rf_write_en", 32'(rfWriteEn), 32'd0);
    checkOutput("abort.wb_ready",    32'(wbReady),   32'd0);
    checkOutput("abort.req_ready",   32'(reqReady),  32'd0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkModel();
    checkOutput("abort.rsp_valid_after", 32'(rspValid), 32'd0);
    checkOutput("abort.req_ready_after", 32'(reqReady), 32'd1);
    checkOutput("abort.rsp_a_cleared",   32'(rspA),     32'd0);
    advance();
    cycle(0, 0, 0, 0, 1, 2, 4, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkModel();
    checkOutput("abort.retry_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("abort.retry_rsp_a",     32'(rspA),     32'h21);
    checkOutput("abort.retry_rsp_b",     32'(rspB),     32'h42);
    advance();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      int rst, wbV, wbA, wbD, rqV, aA, aB, rdy;
      rst = ($urandom_range(0, 39) == 0) ? 1 : 0;
      wbV = ($urandom_range(0, 9) < 4) ? 1 : 0;
      wbA = $urandom_range(0, 2**D - 1);
      wbD = $urandom_range(0, 2**W - 1);
      rqV = ($urandom_range(0, 1) == 1) ? 1 : 0;
      aA  = $urandom_range(0, 2**D - 1);
      aB  = ($urandom_range(0, 3) == 0) ? aA : $urandom_range(0, 2**D - 1);
      rdy = ($urandom_range(0, 2) != 0) ? 1 : 0;
      cycle(rst, wbV, wbA, wbD, rqV, aA, aB, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
